// File: rtl/fibre_tx_framer_if.sv
`default_nettype none
// ============================================================================
// Module      : fibre_tx_framer_if
// Description : Byte stream handshake (valid/ready) into the fibre framer.
// Revision    : 1.0 - initial release
// ============================================================================
interface fibre_tx_framer_if;
    logic [7:0] d_in;
    logic       d_in_valid;
    logic       d_in_ready;

    modport master (output d_in, output d_in_valid, input d_in_ready);
    modport slave  (input d_in, input d_in_valid, output d_in_ready);
endinterface
`default_nettype wire

// File: rtl/fibre_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : fibre_tx_framer
// Description : Byte-to-serial 10-bit line framer with idle fill and periodic
//               sync characters. Optional PRBS7 test mode: FIBRE_TX_PRBS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fibre_tx_framer #(
    parameter int SYNC_INTERVAL = 64
) (
    input  wire              clk_bit,
    input  wire              rst_n,
    fibre_tx_framer_if.slave bus,
`ifdef FIBRE_TX_PRBS_EN
    input  wire              prbs_on,
`endif
    output logic             out,
    output logic             char_start,
    output logic             sync_sent
);

    localparam int                c_SC_W         = (SYNC_INTERVAL > 2) ? $clog2(SYNC_INTERVAL) : 1;
    localparam logic [c_SC_W-1:0] c_SYNC_LAST    = c_SC_W'(SYNC_INTERVAL - 1);
    localparam logic [c_SC_W-1:0] c_SC_ONE       = c_SC_W'(1);
    localparam logic [3:0]        c_BIT_LAST     = 4'd9;
    localparam logic [7:0]        c_IDLE_PAYLOAD = 8'hAA;
    localparam logic [7:0]        c_SYNC_PAYLOAD = 8'h00;

    logic [3:0]        r_bit_cnt;
    logic [c_SC_W-1:0] r_sync_cnt;
    logic [8:0]        r_shift;
    logic [7:0]        r_hold_data;
    logic              r_hold_full;

    logic              w_load;
    logic              w_sync_slot;
    logic              w_accept;
    logic              w_marker_a;
    logic              w_marker_b;
    logic [7:0]        w_payload;
    logic              w_take_hold;

    assign w_load      = (r_bit_cnt == c_BIT_LAST);
    assign w_sync_slot = (r_sync_cnt == c_SYNC_LAST);
    assign w_accept    = bus.d_in_valid && bus.d_in_ready;

`ifdef FIBRE_TX_PRBS_EN
    logic [6:0] r_prbs;
    logic       r_prbs_mode;
    logic [6:0] w_prbs_next;
    logic [7:0] w_prbs_byte;

    // Eight PRBS7 steps per data character; first generated bit is payload bit0.
    always_comb begin
        w_prbs_next = r_prbs;
        w_prbs_byte = 8'h00;
        for (int i = 0; i < 8; i++) begin
            w_prbs_byte[i] = w_prbs_next[6] ^ w_prbs_next[5];
            w_prbs_next    = {w_prbs_next[5:0], w_prbs_byte[i]};
        end
    end

    always_ff @(posedge clk_bit or negedge rst_n) begin
        if (!rst_n) begin
            r_prbs      <= 7'h7F;
            r_prbs_mode <= 1'b0;
        end else if (w_load) begin
            r_prbs_mode <= prbs_on;
            if (!w_sync_slot && prbs_on) begin
                r_prbs <= w_prbs_next;
            end
        end
    end

    assign bus.d_in_ready = ~r_hold_full & ~r_prbs_mode;
`else
    assign bus.d_in_ready = ~r_hold_full;
`endif

    // Character selection for the next load edge, highest priority first.
    always_comb begin
        w_marker_a  = 1'b1;
        w_marker_b  = 1'b0;
        w_payload   = c_IDLE_PAYLOAD;
        w_take_hold = 1'b0;
        if (w_sync_slot) begin
            w_marker_b = 1'b1;
            w_payload  = c_SYNC_PAYLOAD;
        end
`ifdef FIBRE_TX_PRBS_EN
        else if (prbs_on) begin
            w_marker_a = 1'b0;
            w_marker_b = 1'b1;
            w_payload  = w_prbs_byte;
        end
`endif
        else if (r_hold_full) begin
            w_marker_a  = 1'b0;
            w_marker_b  = 1'b1;
            w_payload   = r_hold_data;
            w_take_hold = 1'b1;
        end
    end

    always_ff @(posedge clk_bit or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= c_BIT_LAST;
            r_sync_cnt  <= c_SYNC_LAST;
            r_shift     <= 9'h000;
            r_hold_data <= 8'h00;
            r_hold_full <= 1'b0;
            out         <= 1'b0;
            char_start  <= 1'b0;
            sync_sent   <= 1'b0;
        end else begin
            char_start <= 1'b0;
            sync_sent  <= 1'b0;
            if (w_load) begin
                r_bit_cnt  <= 4'd0;
                out        <= w_marker_a;
                r_shift    <= {w_payload, w_marker_b};
                char_start <= 1'b1;
                sync_sent  <= w_sync_slot;
                r_sync_cnt <= w_sync_slot ? '0 : r_sync_cnt + c_SC_ONE;
            end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
                out       <= r_shift[0];
                r_shift   <= {1'b0, r_shift[8:1]};
            end

            // Accept needs an empty hold and consume needs a full one, so they never collide.
            if (w_accept) begin
                r_hold_full <= 1'b1;
                r_hold_data <= bus.d_in;
            end else if (w_load && w_take_hold) begin
                r_hold_full <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fibre_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fibre_tx_framer
// Description : Self-checking bench for fibre_tx_framer against a slot-level
//               reference model; PRBS section active with FIBRE_TX_PRBS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fibre_tx_framer;

    localparam int SI = 4;

    logic clk_bit = 1'b0;
    logic rst_n   = 1'b0;
    logic out, char_start, sync_sent;
    logic prbs_on = 1'b0;

    fibre_tx_framer_if bus ();

    fibre_tx_framer #(.SYNC_INTERVAL(SI)) dut (
        .clk_bit    (clk_bit),
        .rst_n      (rst_n),
        .bus        (bus),
`ifdef FIBRE_TX_PRBS_EN
        .prbs_on    (prbs_on),
`endif
        .out        (out),
        .char_start (char_start),
        .sync_sent  (sync_sent)
    );

    always #5 clk_bit = ~clk_bit;

    int total = 0;
    int bad   = 0;

    // Reference model: slot index = edges/10, bit index = edges%10.
    int         m_edges;
    bit         m_full;
    logic [7:0] m_byte;
    logic [9:0] m_char;
    bit         m_sync, m_data, m_acc, m_prbs_mode;
    logic [6:0] m_prbs;
    logic       exp_out, exp_cs, exp_ss, exp_ready;
    logic [7:0] sent_q[$];

    // Line decoder fed from the DUT outputs.
    logic [9:0] dec_bits;
    int         dec_cnt;
    logic [7:0] dut_q[$];

    function automatic logic [9:0] make_char(input logic a, input logic b, input logic [7:0] p);
        return {p, b, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_edges = 0; m_full = 1'b0; m_prbs_mode = 1'b0; m_prbs = 7'h7F;
        m_char = '0; m_sync = 1'b0; m_data = 1'b0; m_acc = 1'b0;
        exp_out = 1'b0; exp_cs = 1'b0; exp_ss = 1'b0; exp_ready = 1'b1;
        dec_cnt = 0;
    endtask

    task automatic model_edge();
        int         pos;
        bit         rdy;
        logic [7:0] pay;
        logic       fb;
        pos   = m_edges % 10;
        rdy   = !m_full && !m_prbs_mode;
        m_acc = 1'b0;
        if (pos == 0) begin
            m_sync = ((m_edges / 10) % SI) == 0;
            m_data = 1'b0;
            if (m_sync) begin
                m_char = make_char(1'b1, 1'b1, 8'h00);
            end else if (prbs_on) begin
                for (int i = 0; i < 8; i++) begin
                    fb = m_prbs[6] ^ m_prbs[5];
                    pay[i] = fb;
                    m_prbs = {m_prbs[5:0], fb};
                end
                m_char = make_char(1'b0, 1'b1, pay);
                m_data = 1'b1;
                sent_q.push_back(pay);
            end else if (m_full) begin
                m_char = make_char(1'b0, 1'b1, m_byte);
                m_data = 1'b1;
                m_full = 1'b0;
                sent_q.push_back(m_byte);
            end else begin
                m_char = make_char(1'b1, 1'b0, 8'hAA);
            end
            m_prbs_mode = prbs_on;
        end
        if (bus.d_in_valid && rdy) begin
            m_full = 1'b1;
            m_byte = bus.d_in;
            m_acc  = 1'b1;
        end
        exp_out   = m_char[pos];
        exp_cs    = (pos == 0);
        exp_ss    = (pos == 0) && m_sync;
        exp_ready = !m_full && !m_prbs_mode;
        m_edges++;
    endtask

    task automatic check_outputs();
        chk("out", out, exp_out);
        chk("char_start", char_start, exp_cs);
        chk("sync_sent", sync_sent, exp_ss);
        chk("d_in_ready", bus.d_in_ready, exp_ready);
        if (rst_n) begin
            if (char_start) dec_cnt = 0;
            if (dec_cnt < 10) begin
                dec_bits[dec_cnt] = out;
                dec_cnt++;
                if (dec_cnt == 10 && dec_bits[1:0] == 2'b10) dut_q.push_back(dec_bits[9:2]);
            end
        end
    endtask

    task automatic step();
        @(posedge clk_bit);
        if (rst_n) model_edge();
        @(negedge clk_bit);
        check_outputs();
    endtask

    task automatic cap_char(output logic [9:0] v);
        for (int k = 0; k < 10; k++) begin
            step();
            v[k] = out;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.d_in_valid = 1'b1;
        bus.d_in       = b;
        for (int n = 0; n < 40; n++) begin
            step();
            if (m_acc) begin
                bus.d_in_valid = 1'b0;
                return;
            end
        end
        total++; bad++;
        $display("FAIL accept_timeout: byte %0h not accepted within 40 cycles", b);
        bus.d_in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] v;
        logic [7:0] exp5 [5];
        int         sz, idx;
        bit         found;
        exp5 = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04};
        bus.d_in_valid = 1'b0;
        bus.d_in       = 8'h00;
        model_reset();

        repeat (2) step();
        rst_n = 1'b1;

        cap_char(v);
        chk("first_char_sync", v, 10'b0000000011);

        repeat (3) step();
        bus.d_in_valid = 1'b1; bus.d_in = 8'hA5;
        step();
        bus.d_in_valid = 1'b0; bus.d_in = 8'h5A;
        repeat (6) step();
        cap_char(v);
        chk("data_char_a5", v, 10'b1010010110);
        cap_char(v);
        chk("idle_char", v, 10'b1010101001);

        for (int b = 1; b <= 4; b++) send_byte(8'(b));
        repeat (60) step();
        chk("b2b_count", dut_q.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < dut_q.size()) chk("b2b_byte", dut_q[i], exp5[i]);

        // Reset while bit 5 of a data character is on the line and hold is full.
        bus.d_in_valid = 1'b1; bus.d_in = 8'h10;
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            step();
            if (m_acc) bus.d_in = bus.d_in + 8'd1;
            if (m_data && m_full && (m_edges % 10) == 6) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            total++; bad++;
            $display("FAIL reset_setup: no data character with full hold found");
        end
        bus.d_in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_out", out, 1'b0);
        chk("rst_async_ready", bus.d_in_ready, 1'b1);
        if (m_data) void'(sent_q.pop_back());
        model_reset();
        sz = dut_q.size();
        repeat (2) step();
        rst_n = 1'b1;
        cap_char(v);
        chk("post_reset_sync", v, 10'b0000000011);
        repeat (40) step();
        chk("held_byte_dropped", dut_q.size(), sz);

        for (int n = 0; n < 2000; n++) begin
            bus.d_in_valid = ($urandom_range(0, 3) != 0);
            bus.d_in       = 8'($urandom);
            step();
        end
        bus.d_in_valid = 1'b0;
        repeat (50) step();

`ifdef FIBRE_TX_PRBS_EN
        m_prbs = m_prbs;
        idx = dut_q.size();
        prbs_on = 1'b1;
        bus.d_in_valid = 1'b1; bus.d_in = 8'h77;
        repeat (100) step();
        chk("prbs_first_present", (dut_q.size() > idx), 1'b1);
        if (dut_q.size() > idx) chk("prbs_first_payload", dut_q[idx], 8'h40);
        prbs_on = 1'b0;
        bus.d_in_valid = 1'b0;
        repeat (60) step();
`else
        idx = 0;
`endif

        chk("stream_len", dut_q.size(), sent_q.size());
        for (int i = 0; i < dut_q.size() && i < sent_q.size(); i++)
            chk("stream_byte", dut_q[i], sent_q[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fibre_tx_framer.md
Name: fibre_tx_framer

Overview:
Byte-to-serial line framer for the fibre link transmitter, in the bit-clock domain (clk_bit).
- Accepts bytes on a valid/ready handshake.
- Wraps each byte in a 10-bit character and emits one line bit per clk_bit cycle.
- Fills gaps with idle characters and inserts a periodic sync character, so the link receiver can lock and reframe.
- Drives the optical transmitter pin directly.

Parameters:
- SYNC_INTERVAL, 64, characters per sync period: one sync plus SYNC_INTERVAL-1 data/idle slots; legal range 2..1024.

Ports:
- clk_bit  input  1  bit clock; one line bit per rising edge
- rst_n  input  1  asynchronous active-low reset
- d_in  input  8  byte to transmit
- d_in_valid  input  1  d_in holds a byte
- d_in_ready  output  1  framer can accept a byte this cycle
- out  output  1  serial line bit, registered
- char_start  output  1  high during the first bit of every character
- sync_sent  output  1  high during the first bit of a sync character
- prbs_on  input  1  PRBS test mode; present only with FIBRE_TX_PRBS_EN

Behaviour:
- Reset is asynchronous on the fall of rst_n, released synchronously.
- Reset values:
  - out=0, char_start=0, sync_sent=0, d_in_ready=1 (hold empty)
  - bit_cnt=9, sync_cnt=SYNC_INTERVAL-1
  - shift register 0; PRBS state 7'h7F
- Character format, transmitted in order: marker bit A, marker bit B, payload bit0 .. bit7 (LSB first).
  - data: A,B=0,1; payload = byte
  - idle: A,B=1,0; payload = 8'hAA
  - sync: A,B=1,1; payload = 8'h00
- Holding register: one byte plus a hold_full flag.
  - d_in_ready = ~hold_full, taken straight from the register with no comb path from d_in_valid.
  - A byte is accepted on an edge where d_in_valid && d_in_ready; hold_full is set.
  - d_in is ignored while d_in_ready is low.
- Bit counter bit_cnt runs 0..9.
  - Every edge with bit_cnt<9: shift the next bit to out and increment bit_cnt.
  - On the edge with bit_cnt==9 (load edge), bit_cnt goes to 0.
- Load-edge selection, in priority order:
  1. sync_cnt==SYNC_INTERVAL-1: send sync; sync_cnt<=0; the hold register is retained.
  2. Else if hold_full: send data; hold_full<=0; sync_cnt++.
  3. Else: send idle; sync_cnt++.
- On the load edge, out<=marker A and char_start<=1; sync_sent<=1 if the character is sync. Both pulses last exactly one cycle.
- The first load edge follows reset release directly, so the first character after reset is always sync.
- Latency: a byte accepted while hold is empty is sent in the next non-sync slot. Its first bit appears 1 to 10 cycles after the accept, or 11 to 20 if a sync intervenes.
- Throughput: up to one byte per 10 cycles.
  - d_in_ready rises the cycle after the load edge that consumes hold.
  - This leaves 9 cycles to refill hold before the next load edge, so back-to-back bytes need no idle between them.
- Accept and load on the same edge: the load uses the old hold state. If hold was empty, the new byte waits for the next slot.
- Reset mid-character: the character is truncated, out drops to 0, and any held byte is discarded. Transmission restarts with sync.
- d_in_valid may drop without an accept; nothing is latched in that case.

Optional Feature:
FIBRE_TX_PRBS_EN
- With the macro:
  - Port prbs_on exists.
  - While prbs_on=1:
    - Every non-sync slot is a data character.
    - Payload is the next 8 outputs of PRBS7 (x^7+x^6+1, seed 7'h7F); the generator advances 8 steps per data character.
    - d_in_ready is forced low; any held byte is retained and sent after prbs_on drops.
    - Sync insertion is unchanged.
  - prbs_on is sampled on load edges only.
- Without the macro: no prbs_on port and no PRBS logic; behaviour matches prbs_on=0.

Test Plan:
- Reset release, no valid → first 10 bits 1,1,0,0,0,0,0,0,0,0 with sync_sent pulse on bit 1; then idle characters 1,0,0,1,0,1,0,1,0,1 repeating, char_start every 10 cycles.
- Single byte 8'hA5 accepted during an idle character → next character is 0,1,1,0,1,0,0,1,0,1. d_in_ready is low from the accept until the cycle after that character's load edge.
- d_in_valid held high with bytes 01,02,03,04, SYNC_INTERVAL=64 → four consecutive data characters, no idle between them, one accept per 10 cycles.
- SYNC_INTERVAL=4, continuous data → sync_sent every 40 cycles. The byte held when a sync slot arrives is sent in the following slot, with no loss or duplication (check the byte sequence end to end).
- rst_n asserted on bit 5 of a data character with hold full → out=0 immediately, d_in_ready=1, held byte never appears; first character after release is sync.
- FIBRE_TX_PRBS_EN, prbs_on=1, SYNC_INTERVAL=4 → slots follow the pattern sync then three data; first data payload equals the first 8 PRBS7 bits from seed 7'h7F (golden model); d_in_ready stays 0.
